rv32m_muldiv_unit: RTL and testbench



---
 rtl/rv32m_muldiv_unit_pkg.sv | 29 ++
 rtl/muldiv_div_step.sv | 37 +++
 rtl/rv32m_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_rv32m_muldiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_muldiv_unit_pkg.sv
// rv32m_muldiv_unit_pkg
//   Shared constants for the RV32M iterative multiply/divide unit:
//   funct3 op codes, FSM state encodings, datapath constants and a
//   small two's-complement magnitude helper.
package rv32m_muldiv_unit_pkg;

   localparam int unsigned XLEN     = 32;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   // Magnitude of v when it is to be read as signed (neg set), else v.
   function automatic logic [31:0] abs_val(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step
//   One combinational restoring-division iteration. The partial remainder
//   is shifted left taking in the next dividend bit (MSB of quo_i); the
//   divisor is subtracted when it fits and the quotient bit recorded in
//   the LSB freed by shifting quo_i.
//   rem_i/rem_o     : partial remainder before/after the step
//   quo_i/quo_o     : remaining dividend bits / quotient bits accumulated
//   divisor_i       : divisor magnitude
module muldiv_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);
   import rv32m_muldiv_unit_pkg::*;

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // rem_i < divisor_i holds between steps, so shifted < 2*divisor and
   // the MSB of diff is a reliable "did not fit" flag.
   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {1'b0, divisor_i};
      if (!diff[XLEN]) begin
         rem_o = diff[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Operands are
//   converted to magnitudes on start, processed one shift-add (multiply)
//   or restoring-subtract (divide) step per cycle for ITER cycles, then
//   sign-corrected in FINISH and registered into result with a done pulse.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, funct3       : op request (sampled in IDLE only) and RV32M op
//   operand_a/operand_b : rs1 / rs2 values
//   flush               : abort an in-flight op, no done, result kept
//   busy, done, result  : stall request, one-cycle completion pulse, result
//   Optional macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed
//   overflow skip CALC and complete in two cycles with identical results.
module rv32m_muldiv_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   import rv32m_muldiv_unit_pkg::*;

   localparam int unsigned CW = $clog2(ITER);

   logic [1:0]        state_q,  state_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [2:0]        f3_q,     f3_d;
   logic              sa_q,     sa_d;      // dividend sign -> remainder sign
   logic              neg_q,    neg_d;     // product / quotient sign
   logic [XLEN-1:0]   opnd_q,   opnd_d;    // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc_q,    acc_d;     // {hi,lo} product or {rem,quo}
   logic              done_q,   done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sa, sb, is_div_in;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, prod_fix;
   logic [XLEN-1:0]   div_rem, div_quo, quo_fix, rem_fix, fin_res;
`ifdef MULDIV_FAST_SPECIAL_EN
   logic              special_in;
`endif

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

   muldiv_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i     (acc_q[2*XLEN-1:XLEN]),
      .quo_i     (acc_q[XLEN-1:0]),
      .divisor_i (opnd_q),
      .rem_o     (div_rem),
      .quo_o     (div_quo)
   );

   // Operand decode: MUL and the unsigned ops use magnitudes as-is.
   always_comb begin
      is_div_in = funct3[2];
      sa    = operand_a[XLEN-1] & (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
      sb    = operand_b[XLEN-1] & (funct3 inside {F3_MULH, F3_DIV, F3_REM});
      abs_a = abs_val(operand_a, sa);
      abs_b = abs_val(operand_b, sb);
`ifdef MULDIV_FAST_SPECIAL_EN
      special_in = is_div_in &&
                   ((operand_b == '0) ||
                    (sa && sb && (operand_a == INT_MIN) && (operand_b == ALL_ONES)));
`endif
   end

   // Shift-add multiply step: multiplier sits in acc low half and is
   // consumed LSB first while the product grows in from the top.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
   end

   // Sign fixup and special cases. Signed overflow needs no override:
   // |INT_MIN| / 1 already yields INT_MIN with a positive sign and rem 0.
   always_comb begin
      prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
      quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_fix  = sa_q  ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      case (f3_q)
         F3_MUL:                      fin_res = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             fin_res = (opnd_q == '0) ? ALL_ONES : quo_fix;
         default:                     fin_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      sa_d     = sa_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            // The done cycle is already IDLE; a start there is held off one cycle.
            if (start && !flush && !done_q) begin
               f3_d    = funct3;
               sa_d    = sa;
               neg_d   = sa ^ sb;
               cnt_d   = '0;
               opnd_d  = is_div_in ? abs_b : abs_a;
               acc_d   = {{XLEN{1'b0}}, (is_div_in ? abs_a : abs_b)};
               state_d = S_CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
               // Preload the {rem,quo} the iterations would have produced.
               if (special_in) begin
                  state_d = S_FINISH;
                  acc_d   = (operand_b == '0) ? {abs_a, ALL_ONES}
                                              : {{XLEN{1'b0}}, INT_MIN};
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = f3_q[2] ? {div_rem, div_quo} : mul_next;
            if (cnt_q == CW'(ITER - 1)) begin
               cnt_d   = '0;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FINISH: begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            result_d = fin_res;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         sa_q     <= 1'b0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         sa_q     <= sa_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
module tb_rv32m_muldiv_unit;
   import rv32m_muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   rv32m_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model straight from the RV32M arithmetic definitions.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          ps;
      logic [63:0]     pu;
      logic [31:0]     r;
      case (f3)
         F3_MUL:    begin ps = longint'($signed(a)) * longint'($signed(b)); pu = ps; r = pu[31:0]; end
         F3_MULH:   begin ps = longint'($signed(a)) * longint'($signed(b)); pu = ps; r = pu[63:32]; end
         F3_MULHSU: begin ps = longint'($signed(a)) * longint'({32'b0, b}); pu = ps; r = pu[63:32]; end
         F3_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
         F3_DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                        32'($signed(a) / $signed(b));
         F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM:    r = (b == 0) ? a :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 :
                        32'($signed(a) % $signed(b));
         default:   r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Edges from the start-sampling edge until done is seen.
   function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit special;
      special = f3[2] && ((b == 0) ||
                (((f3 == F3_DIV) || (f3 == F3_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_SPECIAL_EN
      return special ? 1 : 33;
`else
      return (special && 1'b0) ? 1 : 33;
`endif
   endfunction

   // Called #1 after the start-sampling edge. spur>0 drives a competing
   // start for one cycle at that sample point.
   task automatic wait_done(input int spur, output logic [31:0] res, output int lat, output int busy_cnt);
      lat = -1; busy_cnt = 0; res = '0;
      for (int i = 1; i <= 100; i++) begin
         if (busy) busy_cnt++;
         if (i == spur) begin
            start = 1'b1; funct3 = F3_MUL; operand_a = $urandom; operand_b = $urandom;
         end else if (i == spur + 1) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            lat = i; res = result;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int spur);
      logic [31:0] res;
      int lat, bc, el;
      if (done) begin @(posedge clk); #1; end
      @(negedge clk);
      funct3 = f3; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(spur, res, lat, bc);
      el = exp_latency(f3, a, b);
      check({nm, " result"}, 64'(res), 64'(exp));
      check({nm, " latency"}, 64'(lat), 64'(el));
      check({nm, " busy_cycles"}, 64'(bc), 64'(el));
      check({nm, " busy_low_at_done"}, 64'(busy), 64'(0));
   endtask

   initial begin
      vec_t tbl[14];
      logic [31:0] prev, res;
      logic [2:0]  f3;
      logic [31:0] a, b;
      int lat, bc, seen;

      tbl[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      tbl[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tbl[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
      tbl[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
      tbl[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      tbl[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      tbl[6]  = '{F3_DIVU,   32'd100,        32'd7,         32'd14};
      tbl[7]  = '{F3_REMU,   32'd100,        32'd7,         32'd2};
      tbl[8]  = '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
      tbl[9]  = '{F3_REM,    32'd5,          32'd0,         32'd5};
      tbl[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      tbl[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
      tbl[12] = '{F3_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
      tbl[13] = '{F3_REMU,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};

      // Reset state
      #12;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset result", 64'(result), 64'(0));
      @(negedge clk); rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 14; i++)
         do_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, 0);

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom;
         endcase
         do_op($sformatf("rand%0d", i), f3, a, b, model(f3, a, b), 0);
      end

      // Flush mid-divide: no done, result kept, then a fresh op works
      @(posedge clk); #1;
      prev = result;
      @(negedge clk);
      funct3 = F3_DIV; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("flush busy", 64'(busy), 64'(0));
      check("flush done", 64'(done), 64'(0));
      check("flush result_kept", 64'(result), 64'(prev));
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      check("flush no_late_done", 64'(seen), 64'(0));
      do_op("after_flush mul", F3_MUL, 32'd3, 32'd4, 32'd12, 0);

      // Start while busy is ignored
      do_op("start_while_busy", F3_DIVU, 32'd100, 32'd7, 32'd14, 5);

      // Start in the done cycle is held off to the next IDLE cycle
      do_op("pre_done_op", F3_MUL, 32'd5, 32'd6, 32'd30, 0);
      funct3 = F3_MUL; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      check("start_in_done ignored", 64'(busy), 64'(0));
      @(posedge clk); #1;
      start = 1'b0;
      check("start_next_idle accepted", 64'(busy), 64'(1));
      wait_done(0, res, lat, bc);
      check("start_next_idle result", 64'(res), 64'(6));

      // flush + start in IDLE: flush wins
      @(negedge clk); start = 1'b1; flush = 1'b1; funct3 = F3_MUL;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      check("flush_start_idle busy", 64'(busy), 64'(0));

      // Reset mid-CALC
      @(negedge clk);
      funct3 = F3_MULHU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("midreset busy", 64'(busy), 64'(0));
      check("midreset done", 64'(done), 64'(0));
      check("midreset result", 64'(result), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      do_op("after_reset mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
